// File: rtl/snake_head_stepper.sv
// ---------------------------------------------------------------------------
// snake_head_stepper
//
// Moves the snake head one grid cell per movement tick. The direction code
// from the keyboard controller is held as a level, so it is latched into a
// pending register. The pending direction is applied on the next tick, and
// the head wraps around the grid edges like a torus.
//
// Ports
//   VGA_clk     in   1    sole clock, rising edge
//   reset       in   1    asynchronous, active-high
//   direction   in   3    001 up, 010 left, 011 down, 100 right,
//                         111 soft reset, anything else = no request
//   pause       in   1    freezes the tick counter and the head while running
//   head_x      out  X_W  current head column (0..GRID_W-1)
//   head_y      out  Y_W  current head row    (0..GRID_H-1)
//   cur_dir     out  3    direction used by the last step (000 before any step)
//   move_pulse  out  1    one-cycle strobe, aligned with a new head value
//   running     out  1    high while the stepper is in RUN
// ---------------------------------------------------------------------------
module snake_head_stepper #(
    parameter int TICK_DIV = 1000000,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int X_W      = 6,
    parameter int Y_W      = 5,
    parameter int START_X  = 20,
    parameter int START_Y  = 15
) (
    input  logic           VGA_clk,
    input  logic           reset,
    input  logic [2:0]     direction,
    input  logic           pause,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [2:0]     cur_dir,
    output logic           move_pulse,
    output logic           running
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] DIR_NONE  = 3'b000;
    localparam logic [2:0] DIR_UP    = 3'b001;
    localparam logic [2:0] DIR_LEFT  = 3'b010;
    localparam logic [2:0] DIR_DOWN  = 3'b011;
    localparam logic [2:0] DIR_RIGHT = 3'b100;
    localparam logic [2:0] DIR_SOFT  = 3'b111;

    localparam logic [X_W-1:0]   X_START = X_W'(START_X);
    localparam logic [Y_W-1:0]   Y_START = Y_W'(START_Y);
    localparam logic [X_W-1:0]   X_LAST  = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(GRID_H - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TICK_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic [2:0]       pending_dir;
    logic [CNT_W-1:0] tick_cnt;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [2:0]       dir_q;
    logic             pulse_q;

    logic             dir_valid;
    logic             dir_opposite;
    logic             soft_reset;
    logic             tick_end;
    logic [X_W-1:0]   step_x;
    logic [Y_W-1:0]   step_y;

    // Classify the incoming direction code. A reversal is judged against the
    // direction actually travelled (cur_dir), not the pending one, so a quick
    // up->left->down sequence inside one tick still leaves "left" pending.
    always_comb begin
        dir_valid    = (direction == DIR_UP)   || (direction == DIR_LEFT) ||
                       (direction == DIR_DOWN) || (direction == DIR_RIGHT);
        dir_opposite = ((direction == DIR_UP)    && (dir_q == DIR_DOWN))  ||
                       ((direction == DIR_DOWN)  && (dir_q == DIR_UP))    ||
                       ((direction == DIR_LEFT)  && (dir_q == DIR_RIGHT)) ||
                       ((direction == DIR_RIGHT) && (dir_q == DIR_LEFT));
        soft_reset   = (direction == DIR_SOFT);
        tick_end     = (tick_cnt == CNT_END);
    end

    // Candidate head position one cell along the pending direction, with
    // wrap-around at each grid edge so no out-of-range value can appear.
    always_comb begin
        step_x = x_q;
        step_y = y_q;
        case (pending_dir)
            DIR_UP:    step_y = (y_q == '0)     ? Y_LAST : y_q - 1'b1;
            DIR_DOWN:  step_y = (y_q == Y_LAST) ? '0     : y_q + 1'b1;
            DIR_LEFT:  step_x = (x_q == '0)     ? X_LAST : x_q - 1'b1;
            DIR_RIGHT: step_x = (x_q == X_LAST) ? '0     : x_q + 1'b1;
            default: begin
                step_x = x_q;
                step_y = y_q;
            end
        endcase
    end

    // State register.
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: the first valid direction starts the game; the soft
    // reset code returns to IDLE from either state.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dir_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (soft_reset) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode of the state register.
    always_comb begin
        running = (state == RUN);
    end

    // Datapath: direction latch, tick divider and head position. The soft
    // reset takes priority over a tick landing in the same cycle. A step
    // uses the pending direction as it stood before the edge, so a new
    // request presented in the step cycle only affects the following step.
    always_ff @(posedge VGA_clk or posedge reset) begin
        if (reset) begin
            x_q         <= X_START;
            y_q         <= Y_START;
            dir_q       <= DIR_NONE;
            pending_dir <= DIR_NONE;
            tick_cnt    <= '0;
            pulse_q     <= 1'b0;
        end else if (soft_reset) begin
            x_q         <= X_START;
            y_q         <= Y_START;
            dir_q       <= DIR_NONE;
            pending_dir <= DIR_NONE;
            tick_cnt    <= '0;
            pulse_q     <= 1'b0;
        end else if (state == IDLE) begin
            tick_cnt <= '0;
            pulse_q  <= 1'b0;
            if (dir_valid) begin
                pending_dir <= direction;
            end
        end else begin
            pulse_q <= 1'b0;
            if (dir_valid && !dir_opposite) begin
                pending_dir <= direction;
            end
            if (!pause) begin
                if (tick_end) begin
                    tick_cnt <= '0;
                    x_q      <= step_x;
                    y_q      <= step_y;
                    dir_q    <= pending_dir;
                    pulse_q  <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
        end
    end

    assign head_x     = x_q;
    assign head_y     = y_q;
    assign cur_dir    = dir_q;
    assign move_pulse = pulse_q;

endmodule
